// File: rtl/mem8x8_read_mux_pkg.sv
// Shared sizing and state encodings for the mem8x8 read path.
package mem8x8_read_mux_pkg;

  localparam int MEM_WIDTH  = 8;
  localparam int MEM_DEPTH  = 8;
  localparam int MEM_ADDR_W = 3;

  // Kept as plain constants so legacy code can share the same encodings.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OUT  = 1'b1;

endpackage

// File: rtl/mem8x8_read_mux_mux8to1word.sv
// Combinational word selector over a flattened memory image.
// Other read paths reuse this block.
module mux8to1word #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [DEPTH*WIDTH-1:0] i_mem_words,
  input  logic [ADDR_W-1:0]      i_sel,
  output logic [WIDTH-1:0]       o_word
);

  // Pick word i_sel out of the flattened array.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_sel == ADDR_W'(i)) o_word = i_mem_words[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mem8x8_read_mux.sv
// Read side of the 8x8 memory: single or wrapping-burst reads with a
// valid/ready output handshake and a registered data bus.
module mem8x8_read_mux
  import mem8x8_read_mux_pkg::*;
#(
  parameter int WIDTH  = MEM_WIDTH,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DEPTH*WIDTH-1:0] i_mem_words,
  input  logic                   i_rd_req,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  input  logic                   i_rd_burst,
  output logic                   o_rd_ready,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_dout_valid,
  input  logic                   i_dout_ready,
  output logic                   o_dout_last,
  output logic                   o_busy
);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid;
  logic              r_last;

  logic [ADDR_W-1:0] w_sel;
  logic [WIDTH-1:0]  w_word;

  // One mux serves both the first beat (request address) and later beats.
  assign w_sel = (r_state == ST_IDLE) ? i_rd_addr : r_addr;

  mux8to1word #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .i_mem_words (i_mem_words),
    .i_sel       (w_sel),
    .o_word      (w_word)
  );

  // FSM, burst address/count and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rd_req) begin
            r_addr  <= i_rd_addr + ADDR_W'(1);
            r_cnt   <= i_rd_burst ? ADDR_W'(DEPTH - 1) : '0;
            r_dout  <= w_word;
            r_valid <= 1'b1;
            r_last  <= ~i_rd_burst;
            r_state <= ST_OUT;
          end
        end
        default: begin
          // Without dout_ready everything holds, so the stalled word is a
          // snapshot even if the memory changes underneath.
          if (i_dout_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_dout <= w_word;
              r_addr <= r_addr + ADDR_W'(1);
              r_cnt  <= r_cnt - ADDR_W'(1);
              r_last <= (r_cnt == ADDR_W'(1));
            end
          end
        end
      endcase
    end
  end

  assign o_rd_ready   = (r_state == ST_IDLE);
  assign o_busy       = ~o_rd_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_dout_last  = r_last;

endmodule

// File: tb/tb_mem8x8_read_mux.sv
// Directed bench for mem8x8_read_mux: reset, single read, wrapping burst
// with backpressure and ignored requests, and asynchronous reset mid-burst.
module tb_mem8x8_read_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mem;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_burst;
  logic        rd_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem8x8_read_mux dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mem_words  (mem),
    .i_rd_req     (rd_req),
    .i_rd_addr    (rd_addr),
    .i_rd_burst   (rd_burst),
    .o_rd_ready   (rd_ready),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_last  (dout_last),
    .o_busy       (busy)
  );

  typedef struct {
    logic       req;
    logic [2:0] addr;
    logic       burst;
    logic       dready;
    logic [7:0] w7;
    logic [7:0] e_dout;
    logic       e_v;
    logic       e_l;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic req, logic [2:0] addr, logic burst, logic dready,
                              logic [7:0] w7, logic [7:0] e_dout, logic e_v, logic e_l,
                              logic e_rdy);
    vec_t v;
    v.req = req; v.addr = addr; v.burst = burst; v.dready = dready; v.w7 = w7;
    v.e_dout = e_dout; v.e_v = e_v; v.e_l = e_l; v.e_rdy = e_rdy;
    return v;
  endfunction

  // Compares {dout, valid, last, rd_ready, busy} against the expected tuple.
  task automatic check(input string name, input logic [7:0] e_dout, input logic e_v,
                       input logic e_l, input logic e_rdy);
    logic [11:0] got, exp;
    got = {dout, dout_valid, dout_last, rd_ready, busy};
    exp = {e_dout, e_v, e_l, e_rdy, ~e_rdy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got dout=%h v=%b l=%b rdy=%b busy=%b, want dout=%h v=%b l=%b rdy=%b busy=%b",
               name, dout, dout_valid, dout_last, rd_ready, busy,
               e_dout, e_v, e_l, e_rdy, ~e_rdy);
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    mem[i*8 +: 8] = v;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_burst = 1'b0; dout_ready = 1'b0;
    mem = {$urandom, $urandom};

    // Reset with random memory contents
    repeat (3) @(posedge clk);
    #1 check("reset", 8'h00, 1'b0, 1'b0, 1'b1);

    // Single read of word3
    @(negedge clk);
    rst_n = 1'b1;
    set_word(3, 8'hA5);
    rd_req = 1'b1; rd_addr = 3'd3; rd_burst = 1'b0; dout_ready = 1'b1;
    step();
    check("single_beat", 8'hA5, 1'b1, 1'b1, 1'b0);
    rd_req = 1'b0;
    step();
    check("single_done", 8'hA5, 1'b0, 1'b0, 1'b1);

    // Burst from 6 with wrap, stall at beat 2, ignored requests
    for (int i = 0; i < 8; i++) set_word(i, 8'h10 + 8'(i));
    tbl[0]  = mk(1, 3'd6, 1, 1, 8'h17, 8'h16, 1, 0, 0);
    tbl[1]  = mk(0, 3'd0, 0, 1, 8'h17, 8'h17, 1, 0, 0);
    tbl[2]  = mk(0, 3'd0, 0, 0, 8'h17, 8'h17, 1, 0, 0);
    tbl[3]  = mk(0, 3'd0, 0, 0, 8'hEE, 8'h17, 1, 0, 0);
    tbl[4]  = mk(0, 3'd0, 0, 0, 8'hEE, 8'h17, 1, 0, 0);
    tbl[5]  = mk(0, 3'd0, 0, 1, 8'hEE, 8'h10, 1, 0, 0);
    tbl[6]  = mk(0, 3'd0, 0, 1, 8'hEE, 8'h11, 1, 0, 0);
    tbl[7]  = mk(1, 3'd0, 0, 1, 8'hEE, 8'h12, 1, 0, 0);
    tbl[8]  = mk(0, 3'd0, 0, 1, 8'hEE, 8'h13, 1, 0, 0);
    tbl[9]  = mk(0, 3'd0, 0, 1, 8'hEE, 8'h14, 1, 0, 0);
    tbl[10] = mk(0, 3'd0, 0, 1, 8'hEE, 8'h15, 1, 1, 0);
    tbl[11] = mk(1, 3'd0, 0, 1, 8'hEE, 8'h15, 0, 0, 1);
    tbl[12] = mk(0, 3'd0, 0, 1, 8'hEE, 8'h15, 0, 0, 1);

    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      rd_req = tbl[r].req; rd_addr = tbl[r].addr; rd_burst = tbl[r].burst;
      dout_ready = tbl[r].dready;
      set_word(7, tbl[r].w7);
      step();
      check($sformatf("burst_row%0d", r), tbl[r].e_dout, tbl[r].e_v, tbl[r].e_l, tbl[r].e_rdy);
    end

    // Asynchronous reset at beat 4 of a burst from 0
    @(negedge clk);
    set_word(7, 8'h17);
    rd_req = 1'b1; rd_addr = 3'd0; rd_burst = 1'b1; dout_ready = 1'b1;
    step();
    rd_req = 1'b0;
    check("rst_burst_b1", 8'h10, 1'b1, 1'b0, 1'b0);
    step(); step(); step();
    check("rst_burst_b4", 8'h13, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 1'b1; rd_addr = 3'd5; rd_burst = 1'b0;
    step();
    rd_req = 1'b0;
    check("post_rst_read", 8'h15, 1'b1, 1'b1, 1'b0);
    step();
    check("post_rst_done", 8'h15, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
